// File: rtl/mem_if_pkg.sv
// Shared definitions for the byte-masked memory interface: beat geometry,
// initiator state encoding and the request payload driven toward the responder.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_W     = 32;
  localparam int unsigned MEM_BEAT_W     = 128;
  localparam int unsigned MEM_CTRL_W     = 4;
  localparam int unsigned MEM_MAX_CTRL   = 15;
  localparam int unsigned MEM_TAIL_SLACK = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_HOLD  = 3'd2,
    ST_WR_BEAT  = 3'd3,
    ST_FIN      = 3'd4
  } state_e;

  typedef struct packed {
    logic                  en;
    logic                  rdwr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_CTRL_W-1:0] control;
    logic [MEM_BEAT_W-1:0] wr_data;
  } mem_req_t;

  // Bytes for the next beat: the remaining length clamped to the per-beat limit.
  function automatic logic [MEM_CTRL_W-1:0] clamp_chunk(input logic [31:0] remaining,
                                                         input logic [31:0] max_chunk);
    return (remaining > max_chunk) ? MEM_CTRL_W'(max_chunk) : MEM_CTRL_W'(remaining);
  endfunction

endpackage

// File: rtl/mem_if_initiator.sv
// Requester for the byte-masked memory interface: splits a copy descriptor into
// beats of at most MAX_CHUNK bytes, feeding a read stream or draining a write stream.
module mem_if_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned MAX_CHUNK = 15,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [MEM_ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  rdq_valid,
  input  logic                  rdq_ready,
  output logic [MEM_BEAT_W-1:0] rdq_data,
  output logic [MEM_CTRL_W-1:0] rdq_bytes,
  output logic                  rdq_last,
  input  logic                  wrq_valid,
  output logic                  wrq_ready,
  input  logic [MEM_BEAT_W-1:0] wrq_data,
  output logic [MEM_CTRL_W-1:0] wr_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  interface_en,
  output logic                  interface_rdwr,
  output logic [MEM_ADDR_W-1:0] interface_addr,
  output logic [MEM_CTRL_W-1:0] interface_control,
  output logic [MEM_BEAT_W-1:0] interface_wr_data,
  input  logic [MEM_BEAT_W-1:0] interface_rd_data
);

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [MEM_BEAT_W-1:0] buf_q, buf_d;
  logic [MEM_CTRL_W-1:0] cnt_q, cnt_d;
  logic                  ready_q;
  logic [MEM_CTRL_W-1:0] chunk_c;
  logic                  hold_last_c;
  mem_req_t              req_c;

  assign chunk_c     = clamp_chunk(32'(rem_q), 32'(MAX_CHUNK));
  assign hold_last_c = (rem_q == LEN_W'(cnt_q));

  // ready_q keeps cmd_ready low while reset is held and for the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    req_c     = '0;
    cmd_ready = 1'b0;
    rdq_valid = 1'b0;
    rdq_data  = '0;
    rdq_bytes = '0;
    rdq_last  = 1'b0;
    wrq_ready = 1'b0;
    wr_bytes  = '0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = ready_q;
        if (cmd_valid && ready_q) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else if (cmd_write) begin
            state_d = ST_WR_BEAT;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end

      // Responder read data is combinational, so the beat is captured in this cycle.
      ST_RD_ISSUE: begin
        req_c.en      = 1'b1;
        req_c.addr    = addr_q;
        req_c.control = chunk_c;
        buf_d         = interface_rd_data;
        cnt_d         = chunk_c;
        state_d       = ST_RD_HOLD;
      end

      ST_RD_HOLD: begin
        rdq_valid = 1'b1;
        rdq_data  = buf_q;
        rdq_bytes = cnt_q;
        rdq_last  = hold_last_c;
        if (rdq_ready) begin
          addr_d  = addr_q + MEM_ADDR_W'(cnt_q);
          rem_d   = rem_q - LEN_W'(cnt_q);
          state_d = hold_last_c ? ST_FIN : ST_RD_ISSUE;
        end
      end

      // Write data passes straight through; the strobe follows the producer's valid.
      ST_WR_BEAT: begin
        wrq_ready     = 1'b1;
        wr_bytes      = chunk_c;
        req_c.rdwr    = 1'b1;
        req_c.addr    = addr_q;
        req_c.wr_data = wrq_data;
        if (wrq_valid) begin
          req_c.en      = 1'b1;
          req_c.control = chunk_c;
          addr_d        = addr_q + MEM_ADDR_W'(chunk_c);
          rem_d         = rem_q - LEN_W'(chunk_c);
          if (rem_q == LEN_W'(chunk_c)) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign interface_en      = req_c.en;
  assign interface_rdwr    = req_c.rdwr;
  assign interface_addr    = req_c.addr;
  assign interface_control = req_c.control;
  assign interface_wr_data = req_c.wr_data;

endmodule

// File: tb/tb_mem_if_initiator.sv
// Bench for mem_if_initiator: a byte-array responder, a descriptor-level beat model
// and one negedge compare process, plus literal checks on logged beats.
module tb_mem_if_initiator;

  localparam int unsigned LEN_W = 16;
  localparam int          MAXC  = 15;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic         rdq_valid, rdq_ready, rdq_last;
  logic [127:0] rdq_data;
  logic [3:0]   rdq_bytes;
  logic         wrq_valid, wrq_ready;
  logic [127:0] wrq_data;
  logic [3:0]   wr_bytes;
  logic         busy, done;
  logic         interface_en, interface_rdwr;
  logic [31:0]  interface_addr;
  logic [3:0]   interface_control;
  logic [127:0] interface_wr_data, interface_rd_data;

  mem_if_initiator #(.MAX_CHUNK(15), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rdq_valid(rdq_valid), .rdq_ready(rdq_ready), .rdq_data(rdq_data),
    .rdq_bytes(rdq_bytes), .rdq_last(rdq_last),
    .wrq_valid(wrq_valid), .wrq_ready(wrq_ready), .wrq_data(wrq_data),
    .wr_bytes(wr_bytes), .busy(busy), .done(done),
    .interface_en(interface_en), .interface_rdwr(interface_rdwr),
    .interface_addr(interface_addr), .interface_control(interface_control),
    .interface_wr_data(interface_wr_data), .interface_rd_data(interface_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [11:0] i);
    return 8'(32'(i) * 7 + 3);
  endfunction

  function automatic logic [7:0] src(input int i);
    return 8'(160 + i * 3);
  endfunction

  // Responder: 4 KiB byte store aliased over the 32-bit space.
  logic [7:0] mem [0:4095];

  always_comb begin
    interface_rd_data = '0;
    for (int k = 0; k < 16; k++)
      if (k < int'(interface_control))
        interface_rd_data[8*k +: 8] = mem[12'(interface_addr + 32'(k))];
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
    end else if (interface_en && interface_rdwr) begin
      for (int k = 0; k < 16; k++)
        mem[12'(interface_addr + 32'(k))] <= (k < int'(interface_control)) ?
                                             interface_wr_data[8*k +: 8] : 8'h00;
    end
  end

  typedef struct packed {
    logic [31:0]  addr;
    logic         rdwr;
    logic [3:0]   ctrl;
    logic [127:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   bytes;
    logic         last;
  } rdb_t;

  acc_t exp_acc[$];
  rdb_t exp_rd[$];
  acc_t log_acc[$];
  int   log_cyc[$];
  rdb_t log_rd[$];

  function automatic logic [127:0] wbeat(input int o, input int n);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = (k < n) ? src(o + k) : 8'hEE;
    return d;
  endfunction

  function automatic logic [127:0] rbeat(input logic [31:0] a, input int o, input int n);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[8*k +: 8] = pat(12'(a + 32'(o + k)));
    return d;
  endfunction

  // Descriptor-level model: a byte range cut into beats of min(rest, MAXC).
  task automatic model_cmd(input logic [31:0] a, input int len, input bit wr);
    int   o, n;
    acc_t x;
    rdb_t r;
    o = 0;
    while (o < len) begin
      n       = (len - o > MAXC) ? MAXC : len - o;
      x.addr  = a + 32'(o);
      x.rdwr  = wr;
      x.ctrl  = 4'(n);
      x.wdata = wr ? wbeat(o, n) : 128'(0);
      exp_acc.push_back(x);
      if (!wr) begin
        r.data  = rbeat(a, o, n);
        r.bytes = 4'(n);
        r.last  = (o + n == len);
        exp_rd.push_back(r);
      end
      o += n;
    end
  endtask

  // Compare process.
  int   done_cnt = 0, done_cyc = -1, last_en_cyc = -1, last_rdhs_cyc = -1;
  logic stall_q = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_bytes;
  acc_t ea, ga;
  rdb_t er, gr;

  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      check("busy_vs_cmd_ready", 128'(busy & cmd_ready), 128'(0));
      if (!wrq_ready) check("wr_data_zero_outside_write", interface_wr_data, 128'(0));
      if (interface_en) begin
        ga = '{interface_addr, interface_rdwr, interface_control, interface_wr_data};
        log_acc.push_back(ga);
        log_cyc.push_back(cyc);
        last_en_cyc = cyc;
        if (exp_acc.size() == 0) begin
          check("unexpected_access", 128'(1), 128'(0));
        end else begin
          ea = exp_acc.pop_front();
          check("acc_addr", 128'(interface_addr), 128'(ea.addr));
          check("acc_rdwr", 128'(interface_rdwr), 128'(ea.rdwr));
          check("acc_ctrl", 128'(interface_control), 128'(ea.ctrl));
          if (ea.rdwr) begin
            check("acc_wdata", interface_wr_data, ea.wdata);
            check("wr_bytes", 128'(wr_bytes), 128'(ea.ctrl));
          end
        end
      end else begin
        check("ctrl_zero_without_en", 128'(interface_control), 128'(0));
      end
      if (rdq_valid) begin
        check("no_issue_while_holding", 128'(interface_en), 128'(0));
        if (stall_q) begin
          check("rdq_data_stable", rdq_data, held_data);
          check("rdq_bytes_stable", 128'(rdq_bytes), 128'(held_bytes));
        end
        if (rdq_ready) begin
          gr = '{rdq_data, rdq_bytes, rdq_last};
          log_rd.push_back(gr);
          last_rdhs_cyc = cyc;
          stall_q = 1'b0;
          if (exp_rd.size() == 0) begin
            check("unexpected_rd_beat", 128'(1), 128'(0));
          end else begin
            er = exp_rd.pop_front();
            check("rdq_data", rdq_data, er.data);
            check("rdq_bytes", 128'(rdq_bytes), 128'(er.bytes));
            check("rdq_last", 128'(rdq_last), 128'(er.last));
          end
        end else begin
          stall_q    = 1'b1;
          held_data  = rdq_data;
          held_bytes = rdq_bytes;
        end
      end else begin
        stall_q = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Stimulus helpers.
  int cmd_cyc = -1;

  task automatic send_cmd(input logic [31:0] a, input int len, input bit wr);
    bit hs;
    int b;
    hs = 1'b0;
    b  = 0;
    model_cmd(a, len, wr);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 16'(len);
    cmd_write = wr;
    while (!hs && b < 50) begin
      @(negedge clk);
      hs = cmd_ready;
      if (hs) cmd_cyc = cyc;
      @(posedge clk);
      #1;
      b++;
    end
    cmd_valid = 1'b0;
    if (!hs) check("cmd_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic produce(input int len, input int max_beats, output int sent);
    int  o, n, b, beats;
    bit  hs;
    o = 0; b = 0; beats = 0;
    while (o < len && beats < max_beats && b < 200) begin
      n         = (len - o > MAXC) ? MAXC : len - o;
      wrq_valid = 1'b1;
      wrq_data  = wbeat(o, n);
      @(negedge clk);
      hs = wrq_ready && wrq_valid;
      @(posedge clk);
      #1;
      b++;
      if (hs) begin
        o += n;
        beats++;
      end
    end
    wrq_valid = 1'b0;
    sent = o;
  endtask

  task automatic wait_done(input int base);
    int b;
    b = 0;
    while (done_cnt == base && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (done_cnt == base) check("done_timeout", 128'(0), 128'(1));
  endtask

  task automatic clear_logs();
    log_acc.delete();
    log_cyc.delete();
    log_rd.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  int base, sent;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    rdq_ready = 1'b1; wrq_valid = 1'b0; wrq_data = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_en", 128'(interface_en), 128'(0));
    check("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_rdq_valid", 128'(rdq_valid), 128'(0));
    check("rst_wrq_ready", 128'(wrq_ready), 128'(0));
    check("rst_ctrl", 128'(interface_control), 128'(0));
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready_low", 128'(cmd_ready), 128'(0));
    @(posedge clk);
    #1;
    check("idle_cmd_ready", 128'(cmd_ready), 128'(1));

    // Two-beat read.
    clear_logs(); base = done_cnt;
    send_cmd(32'h40, 20, 1'b0);
    wait_done(base);
    check("t1_done_after_last_beat", 128'(done_cyc), 128'(last_rdhs_cyc + 1));
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_once", 128'(done_cnt), 128'(base + 1));
    check("t1_n_acc", 128'(log_acc.size()), 128'(2));
    check("t1_n_rd", 128'(log_rd.size()), 128'(2));
    if (log_acc.size() == 2 && log_rd.size() == 2) begin
      check("t1_addr0", 128'(log_acc[0].addr), 128'(32'h40));
      check("t1_ctrl0", 128'(log_acc[0].ctrl), 128'(15));
      check("t1_addr1", 128'(log_acc[1].addr), 128'(32'h4F));
      check("t1_ctrl1", 128'(log_acc[1].ctrl), 128'(5));
      check("t1_bytes0", 128'(log_rd[0].bytes), 128'(15));
      check("t1_last0", 128'(log_rd[0].last), 128'(0));
      check("t1_bytes1", 128'(log_rd[1].bytes), 128'(5));
      check("t1_last1", 128'(log_rd[1].last), 128'(1));
      check("t1_upper_lanes_zero", 128'(log_rd[1].data[127:40]), 128'(0));
      check("t1_lane0_b1", 128'(log_rd[1].data[7:0]), 128'(pat(12'h04F)));
    end

    // Streaming write, one beat per cycle.
    clear_logs(); base = done_cnt;
    send_cmd(32'h100, 30, 1'b1);
    produce(30, 100, sent);
    check("t2_sent", 128'(sent), 128'(30));
    wait_done(base);
    check("t2_done_after_last_beat", 128'(done_cyc), 128'(last_en_cyc + 1));
    check("t2_n_acc", 128'(log_acc.size()), 128'(2));
    if (log_acc.size() == 2) begin
      check("t2_addr0", 128'(log_acc[0].addr), 128'(32'h100));
      check("t2_ctrl0", 128'(log_acc[0].ctrl), 128'(15));
      check("t2_addr1", 128'(log_acc[1].addr), 128'(32'h10F));
      check("t2_ctrl1", 128'(log_acc[1].ctrl), 128'(15));
      check("t2_back_to_back", 128'(log_cyc[1]), 128'(log_cyc[0] + 1));
    end
    for (int i = 0; i < 30; i++) check("t2_mem", 128'(mem[12'h100 + 12'(i)]), 128'(src(i)));
    check("t2_tail_zero", 128'(mem[12'h11E]), 128'(0));

    // Read with five cycles of backpressure on the first beat.
    clear_logs(); base = done_cnt;
    rdq_ready = 1'b0;
    send_cmd(32'h60, 20, 1'b0);
    begin
      int n, b;
      n = 0; b = 0;
      while (n < 5 && b < 50) begin
        @(negedge clk);
        if (rdq_valid) n++;
        b++;
      end
      check("t3_stall_reached", 128'(n), 128'(5));
    end
    check("t3_single_issue_in_stall", 128'(log_acc.size()), 128'(1));
    @(posedge clk);
    #1 rdq_ready = 1'b1;
    wait_done(base);
    check("t3_n_acc", 128'(log_acc.size()), 128'(2));
    check("t3_n_rd", 128'(log_rd.size()), 128'(2));

    // Zero-length descriptor.
    clear_logs(); base = done_cnt;
    send_cmd(32'h500, 0, 1'b0);
    wait_done(base);
    check("t4_done_one_after_accept", 128'(done_cyc), 128'(cmd_cyc + 1));
    check("t4_no_access", 128'(log_acc.size()), 128'(0));
    check("t4_cmd_ready_back", 128'(cmd_ready), 128'(1));
    check("t4_busy_low", 128'(busy), 128'(0));

    // Reset in the middle of a write descriptor.
    clear_logs(); base = done_cnt;
    send_cmd(32'h300, 45, 1'b1);
    produce(45, 1, sent);
    check("t5_first_beat", 128'(sent), 128'(15));
    wrq_valid = 1'b1;
    wrq_data  = wbeat(15, 15);
    #1;
    check("t5_en_before_rst", 128'(interface_en), 128'(1));
    #1 rst = 1'b0;
    #1;
    check("t5_en_async_drop", 128'(interface_en), 128'(0));
    check("t5_busy_in_rst", 128'(busy), 128'(0));
    check("t5_ready_in_rst", 128'(cmd_ready), 128'(0));
    exp_acc.delete();
    exp_rd.delete();
    wrq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_idle_ready", 128'(cmd_ready), 128'(1));
    check("t5_idle_busy", 128'(busy), 128'(0));
    check("t5_no_done", 128'(done_cnt), 128'(base));
    check("t5_one_access_only", 128'(log_acc.size()), 128'(1));
    clear_logs();
    send_cmd(32'h200, 4, 1'b0);
    wait_done(base);
    check("t5_read_n_rd", 128'(log_rd.size()), 128'(1));
    if (log_rd.size() == 1) begin
      check("t5_read_bytes", 128'(log_rd[0].bytes), 128'(4));
      check("t5_read_last", 128'(log_rd[0].last), 128'(1));
    end

    // Address wrap past 0xFFFFFFFF.
    clear_logs(); base = done_cnt;
    send_cmd(32'hFFFF_FFF8, 20, 1'b0);
    wait_done(base);
    check("t6_n_acc", 128'(log_acc.size()), 128'(2));
    if (log_acc.size() == 2) begin
      check("t6_addr0", 128'(log_acc[0].addr), 128'(32'hFFFF_FFF8));
      check("t6_addr1", 128'(log_acc[1].addr), 128'(32'h0000_0007));
      check("t6_ctrl1", 128'(log_acc[1].ctrl), 128'(5));
    end

    repeat (2) @(posedge clk);
    #1;
    check("end_exp_acc_empty", 128'(exp_acc.size()), 128'(0));
    check("end_exp_rd_empty", 128'(exp_rd.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_if_initiator.md
Name: mem_if_initiator

Overview:
- Requester side of the byte-masked memory interface (en / rdwr / addr / 128-bit data / 4-bit byte-count control).
- Accepts a copy descriptor: start address, byte length, direction.
- Splits the descriptor into beats of at most MAX_CHUNK bytes and drives the interface.
- Read data leaves on a valid/ready beat stream; write data is taken from a valid/ready beat stream. Sits between the accelerator data movers and the data memory.

Parameters:
- MAX_CHUNK, 15: max bytes per interface beat; legal range 1..15 (control is 4 bits).
- LEN_W, 16: width of the descriptor byte-length field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  descriptor offered
- cmd_ready  out  1  descriptor accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write memory from wrq stream; 0 = read memory to rdq stream
- cmd_addr  in  32  start byte address
- cmd_len  in  LEN_W  total bytes; 0 is legal
- rdq_valid  out  1  read beat available
- rdq_ready  in  1  consumer accepts read beat
- rdq_data  out  128  read beat; lane k = byte addr+k
- rdq_bytes  out  4  valid bytes in beat, lanes 0..rdq_bytes-1
- rdq_last  out  1  final beat of descriptor
- wrq_valid  in  1  write beat offered
- wrq_ready  out  1  write beat accepted
- wrq_data  in  128  write beat; producer packs lanes 0..wr_bytes-1
- wr_bytes  out  4  bytes the current write beat must carry
- busy  out  1  descriptor in progress
- done  out  1  one-cycle pulse on descriptor completion
- interface_en, interface_rdwr  out  1 each  access strobe; 1 = write
- interface_addr  out  32  beat address
- interface_control  out  4  byte count for the beat
- interface_wr_data  out  128  write beat data
- interface_rd_data  in  128  combinational read data from responder

Behaviour:
- Reset (async assert, rst low), all outputs 0; FSM in IDLE:
  - interface_en=0; cmd_ready=0 during reset, then 1 in IDLE.
  - Any in-flight descriptor is dropped; no partial beat is issued after rst deasserts.
- Responder contract:
  - Reads are combinational; data is valid in the same cycle addr and control are driven.
  - Writes commit at posedge when en && rdwr.
  - Responder returns 0 in lanes >= control on read.
  - Responder writes 0 to addr+control..addr+15 on write, so every write region needs 16 bytes of tail slack.
- Internal registers: cur_addr (32), remaining (LEN_W), beat buffer (128), buffered count (4).
- chunk = min(remaining, MAX_CHUNK).
- FSM states: IDLE, RD_ISSUE, RD_HOLD, WR_BEAT, FIN.
- IDLE:
  - cmd_ready=1. On handshake, latch addr and len.
  - len==0 -> FIN; cmd_write -> WR_BEAT; else -> RD_ISSUE.
- RD_ISSUE (exactly 1 cycle):
  - Drive en=1, rdwr=0, addr=cur_addr, control=chunk.
  - At the posedge, capture interface_rd_data and chunk into the buffer -> RD_HOLD.
- RD_HOLD:
  - en=0; rdq_valid=1; rdq_data/rdq_bytes from the buffer; rdq_last = (remaining==buffered count).
  - On rdq_ready: cur_addr += count, remaining -= count; then FIN if remaining becomes 0, else RD_ISSUE.
  - Throughput is 1 beat per 2 cycles minimum; backpressure holds the buffer stable.
- WR_BEAT:
  - wr_bytes=chunk; wrq_ready=1.
  - interface_en=wrq_valid, rdwr=1, addr=cur_addr, control=chunk, interface_wr_data=wrq_data (combinational pass-through).
  - On wrq_valid: advance address and remaining by chunk; go to FIN when remaining reaches 0.
  - Throughput is 1 beat/cycle.
- FIN: done=1 for one cycle, busy=0 next -> IDLE.
- busy=1 in every state except IDLE.
- Idle outputs: interface_wr_data=0 outside WR_BEAT; interface_control=0 whenever en=0.
- cur_addr arithmetic is modulo 2^32; wrap past 0xFFFFFFFF continues at 0.
- cmd_valid is ignored outside IDLE.
- wrq_valid is ignored outside WR_BEAT.

Decomposition:
- Shared package mem_if_pkg:
  - state enum;
  - MEM_BEAT_W=128;
  - MEM_CTRL_W=4;
  - MEM_MAX_CTRL=15;
  - MEM_TAIL_SLACK=16.
- Single module; chunk computation is one comparator, so no sub-module.

Test Plan:
- Read cmd addr=0x40, len=20, MAX_CHUNK=15, rdq_ready=1 -> two RD_ISSUE beats:
  - (0x40, ctrl 15), then (0x4F, ctrl 5);
  - rdq_bytes=15 then 5; rdq_last only on the 2nd;
  - lanes 5..15 of beat 2 = 0; done pulses once.
- Write cmd addr=0x100, len=30, wrq_valid=1 each cycle -> en/rdwr high on 2 consecutive cycles:
  - (0x100, ctrl 15), then (0x10F, ctrl 15);
  - memory 0x100..0x11D matches the stream; 0x11E.. zero-filled; done next cycle.
- Read with rdq_ready low for 5 cycles on beat 1 -> rdq_data stable, en=0 throughout stall; no second issue until the handshake.
- cmd_len=0 -> no interface access; done one cycle after accept; cmd_ready back to 1.
- rst asserted in WR_BEAT mid-descriptor -> en drops asynchronously; after release, IDLE with cmd_ready=1 and busy=0; a new read of len=4 completes normally.
- Wrap: read addr=0xFFFFFFF8, len=20 -> beat addresses 0xFFFFFFF8, then 0x00000007.
